cycle_interval_capture: RTL and testbench

- Sits directly downstream of the free-running cycle counter and consumes its `count` bus.
- Measures elapsed clock cycles between a `start` event and a `stop` event.
- Presents the result on a valid/ready handshake, with modulo-2^CNT_W arithmetic and wrap (overflow) detection.
- Used to time bus transactions and FSM phases without a second free-running counter.

---
 rtl/cycle_interval_capture.sv | 124 ++++++++++++
 tb/tb_cycle_interval_capture.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cycle_interval_capture.sv
// Measures clock cycles between start and stop pulses using an external free-running count.
// Define CAPTURE_MINMAX_EN to track the smallest and largest non-overflowed interval since reset.
module cycle_interval_capture #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] count,
    input  logic             start,
    input  logic             stop,
    input  logic             abort,
    input  logic             rd_ready,
    output logic             busy,
    output logic [CNT_W-1:0] result,
    output logic             result_valid,
    output logic             overflow,
    output logic [CNT_W-1:0] min_interval,
    output logic [CNT_W-1:0] max_interval
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] start_cnt;
    logic             wrap;
    logic [CNT_W-1:0] elapsed;
    logic             count_hit;
    logic             stop_ovf;
    logic             capture;

    // Modulo subtraction gives the interval directly; a repeat of the start count means a full period passed.
    assign elapsed   = count - start_cnt;
    assign count_hit = (count == start_cnt);
    assign stop_ovf  = wrap | count_hit;
    assign capture   = (state == RUN) && stop && !abort;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        busy         = 1'b0;
        result_valid = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (abort) begin
                    state_next = IDLE;
                end else if (stop) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                result_valid = 1'b1;
                if (rd_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            start_cnt <= '0;
            wrap      <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                start_cnt <= count;
                wrap      <= 1'b0;
            end
            // The wrap flag stays set until the next start so a later stop still reports aliasing.
            if (state == RUN && !abort) begin
                if (stop) begin
                    result   <= elapsed;
                    overflow <= stop_ovf;
                end else if (count_hit) begin
                    wrap <= 1'b1;
                end
            end
        end
    end

`ifdef CAPTURE_MINMAX_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            min_interval <= '1;
            max_interval <= '0;
        end else if (capture && !stop_ovf) begin
            if (elapsed < min_interval) begin
                min_interval <= elapsed;
            end
            if (elapsed > max_interval) begin
                max_interval <= elapsed;
            end
        end
    end
`else
    logic unused_capture;
    assign unused_capture = capture;
    assign min_interval   = '0;
    assign max_interval   = '0;
`endif

endmodule

// File: tb/tb_cycle_interval_capture.sv
// Bench for cycle_interval_capture: directed scenarios then random traffic against an elapsed-edge model.
module tb_cycle_interval_capture;

    localparam int    W   = 8;
    localparam longint MOD = longint'(1) << W;

    logic         clk;
    logic         rst;
    logic [W-1:0] count;
    logic         start;
    logic         stop;
    logic         abort;
    logic         rd_ready;
    logic         busy;
    logic [W-1:0] result;
    logic         result_valid;
    logic         overflow;
    logic [W-1:0] min_interval;
    logic [W-1:0] max_interval;

    int total = 0;
    int bad   = 0;

    // Model: measurement is kept as absolute edge numbers, so wrap and overflow fall out of plain arithmetic.
    longint       edge_n = 0;
    longint       m_start_edge = 0;
    bit           m_run  = 0;
    bit           m_done = 0;
    logic [W-1:0] m_result = '0;
    bit           m_ovf  = 0;
    logic [W-1:0] m_min  = '1;
    logic [W-1:0] m_max  = '0;

    cycle_interval_capture #(.CNT_W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .count        (count),
        .start        (start),
        .stop         (stop),
        .abort        (abort),
        .rd_ready     (rd_ready),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .overflow     (overflow),
        .min_interval (min_interval),
        .max_interval (max_interval)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [W-1:0] exp_min;
        logic [W-1:0] exp_max;
`ifdef CAPTURE_MINMAX_EN
        exp_min = m_min;
        exp_max = m_max;
`else
        exp_min = '0;
        exp_max = '0;
`endif
        check_output({tag, ".busy"}, 32'(busy), 32'(m_run));
        check_output({tag, ".valid"}, 32'(result_valid), 32'(m_done));
        check_output({tag, ".result"}, 32'(result), 32'(m_result));
        check_output({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
        check_output({tag, ".min"}, 32'(min_interval), 32'(exp_min));
        check_output({tag, ".max"}, 32'(max_interval), 32'(exp_max));
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then compare just after it.
    task automatic apply_stimulus(input bit s, input bit p, input bit a, input bit r, input bit rs,
                                  input string tag);
        longint n;
        start    = s;
        stop     = p;
        abort    = a;
        rd_ready = r;
        rst      = rs;
        if (rs) begin
            m_run = 0; m_done = 0; m_result = '0; m_ovf = 0; m_min = '1; m_max = '0;
        end else if (m_run) begin
            if (a) begin
                m_run = 0;
            end else if (p) begin
                n        = edge_n - m_start_edge;
                m_result = n[W-1:0];
                m_ovf    = (n >= MOD);
                m_run    = 0;
                m_done   = 1;
                if (!m_ovf) begin
                    if (m_result < m_min) m_min = m_result;
                    if (m_result > m_max) m_max = m_result;
                end
            end
        end else if (m_done) begin
            if (r) m_done = 0;
        end else if (s) begin
            m_run        = 1;
            m_start_edge = edge_n;
        end
        @(posedge clk);
        #1;
        edge_n++;
        count = count + 1'b1;
        check_all(tag);
    endtask

    task automatic idle_until(input logic [W-1:0] target);
        while (count != target) apply_stimulus(0, 0, 0, 0, 0, "idle");
    endtask

    task automatic idle_for(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(0, 0, 0, 0, 0, "idle");
    endtask

    task automatic expect_min_max(input string tag, input logic [W-1:0] mn, input logic [W-1:0] mx);
`ifdef CAPTURE_MINMAX_EN
        check_output({tag, ".min"}, 32'(min_interval), 32'(mn));
        check_output({tag, ".max"}, 32'(max_interval), 32'(mx));
`else
        check_output({tag, ".min"}, 32'(min_interval), 32'd0);
        check_output({tag, ".max"}, 32'(max_interval), 32'd0);
`endif
    endtask

    initial begin
        count = '0;
        start = 0; stop = 0; abort = 0; rd_ready = 0; rst = 1;
        #2;
        apply_stimulus(0, 0, 0, 0, 1, "reset");
        apply_stimulus(0, 0, 0, 0, 1, "reset");
        check_output("reset.busy", 32'(busy), 32'd0);
        check_output("reset.valid", 32'(result_valid), 32'd0);
        check_output("reset.result", 32'(result), 32'd0);
        expect_min_max("reset", '1, '0);

        // Basic interval: 100 -> 137.
        idle_until(8'd100);
        apply_stimulus(1, 0, 0, 0, 0, "basic.start");
        check_output("basic.busy", 32'(busy), 32'd1);
        idle_until(8'd137);
        apply_stimulus(0, 1, 0, 0, 0, "basic.stop");
        check_output("basic.valid", 32'(result_valid), 32'd1);
        check_output("basic.result", 32'(result), 32'd37);
        check_output("basic.ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(0, 0, 0, 0, 0, "basic.hold");
            check_output("basic.hold_result", 32'(result), 32'd37);
        end
        apply_stimulus(0, 0, 0, 1, 0, "basic.ack");
        check_output("basic.ack_valid", 32'(result_valid), 32'd0);
        check_output("basic.ack_busy", 32'(busy), 32'd0);

        // Single counter wrap: 250 -> 5.
        idle_until(8'd250);
        apply_stimulus(1, 0, 0, 0, 0, "wrap.start");
        idle_until(8'd5);
        apply_stimulus(0, 1, 0, 0, 0, "wrap.stop");
        check_output("wrap.result", 32'(result), 32'd11);
        check_output("wrap.ovf", 32'(overflow), 32'd0);
        apply_stimulus(0, 0, 0, 1, 0, "wrap.ack");

        // Interval of 200.
        apply_stimulus(1, 0, 0, 0, 0, "i200.start");
        idle_for(199);
        apply_stimulus(0, 1, 0, 0, 0, "i200.stop");
        check_output("i200.result", 32'(result), 32'd200);
        apply_stimulus(0, 0, 0, 1, 0, "i200.ack");

        // Exactly one full period, then one period plus four.
        idle_until(8'd10);
        apply_stimulus(1, 0, 0, 0, 0, "full.start");
        idle_for(int'(MOD) - 1);
        apply_stimulus(0, 1, 0, 0, 0, "full.stop");
        check_output("full.result", 32'(result), 32'd0);
        check_output("full.ovf", 32'(overflow), 32'd1);
        apply_stimulus(0, 0, 0, 1, 0, "full.ack");
        idle_until(8'd10);
        apply_stimulus(1, 0, 0, 0, 0, "full4.start");
        idle_for(int'(MOD) + 3);
        apply_stimulus(0, 1, 0, 0, 0, "full4.stop");
        check_output("full4.result", 32'(result), 32'd4);
        check_output("full4.ovf", 32'(overflow), 32'd1);
        apply_stimulus(0, 0, 0, 1, 0, "full4.ack");
        expect_min_max("minmax", 8'd11, 8'd200);

        // Priority and ignored inputs.
        apply_stimulus(1, 1, 0, 0, 0, "prio.start_stop");
        check_output("prio.busy", 32'(busy), 32'd1);
        apply_stimulus(0, 1, 1, 0, 0, "prio.stop_abort");
        check_output("prio.abort_valid", 32'(result_valid), 32'd0);
        check_output("prio.abort_result", 32'(result), 32'd4);
        apply_stimulus(1, 0, 0, 0, 0, "ign.start");
        idle_for(3);
        apply_stimulus(1, 0, 0, 0, 0, "ign.start_in_run");
        idle_for(2);
        apply_stimulus(0, 1, 0, 0, 0, "ign.stop");
        check_output("ign.result", 32'(result), 32'd7);
        apply_stimulus(1, 1, 1, 0, 0, "ign.pulses_in_done");
        check_output("ign.done_valid", 32'(result_valid), 32'd1);
        apply_stimulus(1, 0, 0, 1, 0, "ign.start_on_ack");
        check_output("ign.ack_busy", 32'(busy), 32'd0);

        // Reset in RUN, then in DONE.
        apply_stimulus(1, 0, 0, 0, 0, "rrun.start");
        idle_for(4);
        apply_stimulus(0, 0, 0, 0, 1, "rrun.reset");
        check_output("rrun.busy", 32'(busy), 32'd0);
        check_output("rrun.result", 32'(result), 32'd0);
        apply_stimulus(1, 0, 0, 0, 0, "rdone.start");
        idle_for(6);
        apply_stimulus(0, 1, 0, 0, 0, "rdone.stop");
        check_output("rdone.result", 32'(result), 32'd7);
        apply_stimulus(0, 0, 0, 0, 1, "rdone.reset");
        check_output("rdone.valid", 32'(result_valid), 32'd0);
        check_output("rdone.result0", 32'(result), 32'd0);
        check_output("rdone.ovf", 32'(overflow), 32'd0);

        // Random traffic, including occasional long runs and resets.
        for (int i = 0; i < 3000; i++) begin
            bit s, p, a, r, rs;
            s  = ($urandom_range(0, 7) == 0);
            p  = (i % 1000 < 500) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 299) == 0);
            a  = ($urandom_range(0, 39) == 0);
            r  = ($urandom_range(0, 2) == 0);
            rs = ($urandom_range(0, 299) == 0);
            apply_stimulus(s, p, a, r, rs, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
